// File: rtl/arb_mux2_8b_if.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux2_8b_if
// Description : Handshake bundle for the two-requester arbitrating mux.
//               Holds two val/rdy/data inputs and one val/rdy/data/src output.
// Revision    : 1.0 - initial release
// ============================================================================
interface arb_mux2_8b_if #(
  parameter int nbits = 8
);
  logic             in0_val;
  logic             in0_rdy;
  logic [nbits-1:0] in0_data;
  logic             in1_val;
  logic             in1_rdy;
  logic [nbits-1:0] in1_data;
  logic             out_val;
  logic             out_rdy;
  logic [nbits-1:0] out_data;
  logic             out_src;

  // Requester/consumer side: drives the inputs and out_rdy
  modport master (
    output in0_val, in0_data, in1_val, in1_data, out_rdy,
    input  in0_rdy, in1_rdy, out_val, out_data, out_src
  );

  // Arbiter side
  modport slave (
    input  in0_val, in0_data, in1_val, in1_data, out_rdy,
    output in0_rdy, in1_rdy, out_val, out_data, out_src
  );
endinterface
`default_nettype wire

// File: rtl/arb_mux2_8b.sv
`default_nettype none
// ============================================================================
// Module      : arb_mux2_8b
// Description : Two-requester round-robin arbiter feeding a single-entry
//               output buffer. One cycle latency, full throughput when the
//               consumer is ready.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_mux2_8b #(
  parameter int nbits = 8
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active-low
  arb_mux2_8b_if.slave  bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q,  prio_d;
  logic [nbits-1:0] data_q,  data_d;
  logic             src_q,   src_d;

  logic can_accept;
  logic grant;
  logic in0_rdy;
  logic in1_rdy;
  logic in_xfer;
  logic out_xfer;

  // Arbitration, handshake and next-state computation
  always_comb begin
    // The buffer slot frees up this cycle if it is empty or being drained
    can_accept = (state_q == EMPTY) || bus.out_rdy;
    // Lone requester wins outright; a tie is broken by the priority bit
    grant      = bus.in1_val && (!bus.in0_val || prio_q);
    // Gating with reset keeps both rdys low while held in reset
    in0_rdy    = reset && can_accept && bus.in0_val && !grant;
    in1_rdy    = reset && can_accept && bus.in1_val &&  grant;
    in_xfer    = in0_rdy || in1_rdy;
    out_xfer   = (state_q == FULL) && bus.out_rdy;

    state_d = state_q;
    prio_d  = prio_q;
    data_d  = data_q;
    src_d   = src_q;

    if (in_xfer) begin
      // New item replaces any departing one with no bubble
      state_d = FULL;
      data_d  = grant ? bus.in1_data : bus.in0_data;
      src_d   = grant;
      prio_d  = !grant;
    end else if (out_xfer) begin
      state_d = EMPTY;
    end
  end

  // State, priority and output buffer registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      prio_q  <= 1'b0;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign bus.in0_rdy  = in0_rdy;
  assign bus.in1_rdy  = in1_rdy;
  assign bus.out_val  = (state_q == FULL);
  assign bus.out_data = data_q;
  assign bus.out_src  = src_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_mux2_8b.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_mux2_8b
// Description : Scoreboard bench for arb_mux2_8b. Stimulus pushes the
//               hand-computed {src,data} of each accepted item; a monitor
//               pops and compares on every output transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_mux2_8b;

  localparam int c_nbits = 8;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  logic [c_nbits:0] exp_q[$];

  arb_mux2_8b_if #(.nbits(c_nbits)) bus ();

  arb_mux2_8b #(.nbits(c_nbits)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest expected item
  always @(negedge clk) begin
    if (reset && bus.out_val && bus.out_rdy) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got src=%0d data=0x%0h, expected none",
                 bus.out_src, bus.out_data);
      end else begin
        logic [c_nbits:0] e;
        e = exp_q.pop_front();
        check("out_item", {23'd0, bus.out_src, bus.out_data}, {23'd0, e});
      end
    end
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.in0_val  = 1'b1;
    bus.in1_val  = 1'b1;
    bus.in0_data = 8'hFF;
    bus.in1_data = 8'hEE;
    bus.out_rdy  = 1'b1;

    // Reset state with requests pending
    #12;
    check("rst_out_val",  {31'd0, bus.out_val}, 32'd0);
    check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("rst_out_src",  {31'd0, bus.out_src}, 32'd0);
    check("rst_in0_rdy",  {31'd0, bus.in0_rdy}, 32'd0);
    check("rst_in1_rdy",  {31'd0, bus.in1_rdy}, 32'd0);

    // First transfer right after release
    @(negedge clk);
    reset = 1'b1;
    bus.in0_val  = 1'b1;
    bus.in0_data = 8'h3C;
    bus.in1_val  = 1'b0;
    bus.out_rdy  = 1'b1;
    exp_q.push_back({1'b0, 8'h3C});
    #1;
    check("first_in0_rdy", {31'd0, bus.in0_rdy}, 32'd1);
    check("first_in1_rdy", {31'd0, bus.in1_rdy}, 32'd0);
    step();
    check("first_out_val",  {31'd0, bus.out_val}, 32'd1);
    check("first_out_data", {24'd0, bus.out_data}, 32'h3C);
    check("first_out_src",  {31'd0, bus.out_src}, 32'd0);

    // Lone in1 request, also hands priority back to in0
    bus.in0_val  = 1'b0;
    bus.in1_val  = 1'b1;
    bus.in1_data = 8'h77;
    exp_q.push_back({1'b1, 8'h77});
    #1;
    check("lone_in1_rdy", {31'd0, bus.in1_rdy}, 32'd1);
    check("lone_in0_rdy", {31'd0, bus.in0_rdy}, 32'd0);
    step();

    // Both requesting: strict alternation starting at in0
    bus.in0_val  = 1'b1;
    bus.in0_data = 8'hA1;
    bus.in1_val  = 1'b1;
    bus.in1_data = 8'hB2;
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b1, 8'hB2});
    exp_q.push_back({1'b0, 8'hA1});
    exp_q.push_back({1'b1, 8'hB2});
    for (int i = 0; i < 4; i++) begin
      #1;
      check("rr_in0_rdy", {31'd0, bus.in0_rdy}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check("rr_in1_rdy", {31'd0, bus.in1_rdy}, (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
    end
    check("rr_last_src", {31'd0, bus.out_src}, 32'd1);

    // Back-to-back stream from in0 only: no bubbles
    bus.in1_val = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus.in0_data = 8'h10 + 8'(i);
      exp_q.push_back({1'b0, 8'h10 + 8'(i)});
      #1;
      check("stream_in0_rdy", {31'd0, bus.in0_rdy}, 32'd1);
      step();
      check("stream_out_val", {31'd0, bus.out_val}, 32'd1);
    end
    bus.in0_val = 1'b0;
    step();
    check("drain_out_val", {31'd0, bus.out_val}, 32'd0);

    // Backpressure: hold 0x55 while in1 waits
    bus.out_rdy  = 1'b0;
    bus.in0_val  = 1'b1;
    bus.in0_data = 8'h55;
    exp_q.push_back({1'b0, 8'h55});
    step();
    bus.in0_val  = 1'b0;
    bus.in1_val  = 1'b1;
    bus.in1_data = 8'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_in1_rdy",   {31'd0, bus.in1_rdy}, 32'd0);
      check("bp_out_val",   {31'd0, bus.out_val}, 32'd1);
      check("bp_out_data",  {24'd0, bus.out_data}, 32'h55);
      step();
    end
    bus.out_rdy = 1'b1;
    exp_q.push_back({1'b1, 8'h66});
    #1;
    check("bp_release_in1_rdy", {31'd0, bus.in1_rdy}, 32'd1);
    step();
    check("bp_swap_data", {24'd0, bus.out_data}, 32'h66);
    check("bp_swap_src",  {31'd0, bus.out_src}, 32'd1);
    bus.in1_val = 1'b0;
    step();
    step();

    // Fill from in0 (prio becomes 1), then reset mid-cycle while FULL
    bus.out_rdy  = 1'b0;
    bus.in0_val  = 1'b1;
    bus.in0_data = 8'h99;
    step();
    bus.in0_val = 1'b0;
    check("pre_rst_out_val", {31'd0, bus.out_val}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_out_val",  {31'd0, bus.out_val}, 32'd0);
    check("async_rst_out_data", {24'd0, bus.out_data}, 32'd0);
    check("async_rst_out_src",  {31'd0, bus.out_src}, 32'd0);

    // After release prio is 0 again: in0 wins the tie
    @(negedge clk);
    reset        = 1'b1;
    bus.out_rdy  = 1'b1;
    bus.in0_val  = 1'b1;
    bus.in0_data = 8'hA1;
    bus.in1_val  = 1'b1;
    bus.in1_data = 8'hB2;
    exp_q.push_back({1'b0, 8'hA1});
    #1;
    check("post_rst_in0_rdy", {31'd0, bus.in0_rdy}, 32'd1);
    check("post_rst_in1_rdy", {31'd0, bus.in1_rdy}, 32'd0);
    step();
    check("post_rst_out_data", {24'd0, bus.out_data}, 32'hA1);
    check("post_rst_out_src",  {31'd0, bus.out_src}, 32'd0);
    bus.in0_val = 1'b0;
    bus.in1_val = 1'b0;
    step();
    step();
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
